// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: FSM state encoding,
// key code constants and a constant-evaluable ceil(log2) helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } key_state_t;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM turning raw scanner code/press into one registered event per
// keystroke. Auto-repeat while held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_CYC = 20000,
  parameter int REP_DLY = 25000000,
  parameter int REP_PER = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_press,
  output logic       evt,
  output logic [3:0] cand
);

  localparam int MAX_A   = (DEB_CYC > REP_DLY) ? DEB_CYC : REP_DLY;
  localparam int MAX_CYC = (MAX_A > REP_PER) ? MAX_A : REP_PER;
  localparam int CW      = clog2(MAX_CYC);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

  key_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    cand_n;
  logic          evt_n;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] DLY_LAST = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REP_PER - 1);
  logic [CW-1:0] rep_cnt, rep_cnt_n;
  logic          rep_first, rep_first_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
      evt   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
      evt   <= evt_n;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_cnt_n;
      rep_first <= rep_first_n;
`endif
    end
  end

  // Any state change clears the debounce counter; only a full run of matching
  // samples in ARM produces the event.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    evt_n   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_n   = '0;
    rep_first_n = 1'b1;
`endif
    case (state)
      IDLE: begin
        if (key_press) begin
          cand_n  = key_code;
          cnt_n   = '0;
          state_n = ARM;
        end
      end
      ARM: begin
        if (!key_press) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (key_code != cand) begin
          cand_n = key_code;
          cnt_n  = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          evt_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!key_press) begin
          state_n = REL;
          cnt_n   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        // First repeat waits REP_DLY, later ones REP_PER
        else if (rep_cnt == (rep_first ? DLY_LAST : PER_LAST)) begin
          evt_n       = 1'b1;
          rep_first_n = 1'b0;
        end else begin
          rep_cnt_n   = rep_cnt + CW'(1);
          rep_first_n = rep_first;
        end
`endif
      end
      REL: begin
        if (key_press) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/keypad_entry_buf.sv
// Keypad entry buffer: debounced key events shifted into a hex digit register.
// Optional auto-repeat in the debouncer is enabled with KEYPAD_REPEAT_EN.
module keypad_entry_buf
  import keypad_pkg::*;
#(
  parameter int DEB_CYC = 20000,
  parameter int NDIGITS = 4,
  parameter int REP_DLY = 25000000,
  parameter int REP_PER = 5000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     key_code,
  input  logic                           key_press,
  input  logic                           clr,
  output logic                           key_valid,
  output logic [3:0]                     key_val,
  output logic [4*NDIGITS-1:0]           digits,
  output logic [clog2(NDIGITS+1)-1:0]    digit_cnt
);

  localparam int DW = 4 * NDIGITS;
  localparam int NW = clog2(NDIGITS + 1);
  localparam logic [NW-1:0] CNT_MAX = NW'(NDIGITS);

  logic       evt;
  logic [3:0] cand;

  keypad_debounce #(
    .DEB_CYC (DEB_CYC),
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_press (key_press),
    .evt       (evt),
    .cand      (cand)
  );

  // A clear coinciding with an event leaves just the new digit in place
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_val   <= '0;
      digits    <= '0;
      digit_cnt <= '0;
    end else begin
      key_valid <= evt;
      if (evt) key_val <= cand;
      if (clr && evt) begin
        digits    <= DW'(cand);
        digit_cnt <= NW'(1);
      end else if (clr) begin
        digits    <= '0;
        digit_cnt <= '0;
      end else if (evt) begin
        digits <= (digits << 4) | DW'(cand);
        if (digit_cnt != CNT_MAX) digit_cnt <= digit_cnt + NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_buf.sv
// Directed bench for keypad_entry_buf with DEB_CYC=4, NDIGITS=4, REP_DLY=20,
// REP_PER=8; repeat expectations follow KEYPAD_REPEAT_EN.
module tb_keypad_entry_buf;
  import keypad_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  key_code;
  logic        key_press;
  logic        clr;
  logic        key_valid;
  logic [3:0]  key_val;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int evt_count = 0;
  int cycle = 0;
  int ev_cyc[$];
  int base;

  keypad_entry_buf #(
    .DEB_CYC (4),
    .NDIGITS (4),
    .REP_DLY (20),
    .REP_PER (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_press (key_press),
    .clr       (clr),
    .key_valid (key_valid),
    .key_val   (key_val),
    .digits    (digits),
    .digit_cnt (digit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event log sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    cycle++;
    if (key_valid === 1'b1) begin
      evt_count++;
      ev_cyc.push_back(cycle);
    end
  end

  task automatic applyStimulus(input logic [3:0] code, input logic press,
                               input logic clr_v, input int n);
    key_code  = code;
    key_press = press;
    clr       = clr_v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  seq_keys   [5] = '{KEY_1, KEY_2, KEY_3, KEY_4, KEY_A};
  logic [15:0] seq_digits [5] = '{16'h0591, 16'h5912, 16'h9123, 16'h1234, 16'h234A};
  logic [2:0]  seq_cnt    [5] = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd4};

  initial begin
    rst = 1'b1;
    $display("[TB] reset with key held");
    applyStimulus(KEY_C, 1'b1, 1'b0, 2);
    checkOutput("rst_valid", key_valid, 0);
    checkOutput("rst_val", key_val, 0);
    checkOutput("rst_digits", digits, 0);
    checkOutput("rst_cnt", digit_cnt, 0);
    checkOutput("rst_events", evt_count, 0);
    rst = 1'b0;
    applyStimulus(KEY_C, 1'b1, 1'b0, 10);
    checkOutput("post_rst_events", evt_count, 1);
    checkOutput("post_rst_val", key_val, KEY_C);
    checkOutput("post_rst_digits", digits, 16'h000C);
    checkOutput("post_rst_cnt", digit_cnt, 1);
    applyStimulus(KEY_C, 1'b0, 1'b0, 10);
    applyStimulus(KEY_C, 1'b0, 1'b1, 1);
    checkOutput("clr_digits", digits, 0);
    checkOutput("clr_cnt", digit_cnt, 0);
    checkOutput("clr_keeps_val", key_val, KEY_C);

    $display("[TB] clean press of 5");
    applyStimulus(KEY_5, 1'b1, 1'b0, 5);
    checkOutput("clean_early", key_valid, 0);
    applyStimulus(KEY_5, 1'b1, 1'b0, 1);
    checkOutput("clean_pulse", key_valid, 1);
    checkOutput("clean_val", key_val, KEY_5);
    checkOutput("clean_digits", digits, 16'h0005);
    checkOutput("clean_cnt", digit_cnt, 1);
    applyStimulus(KEY_5, 1'b1, 1'b0, 1);
    checkOutput("clean_one_cycle", key_valid, 0);
    applyStimulus(KEY_5, 1'b1, 1'b0, 3);
    applyStimulus(KEY_5, 1'b0, 1'b0, 10);
    checkOutput("clean_events", evt_count, 2);

    $display("[TB] glitch rejection");
    repeat (3) begin
      applyStimulus(KEY_5, 1'b1, 1'b0, 2);
      applyStimulus(KEY_9, 1'b1, 1'b0, 2);
    end
    checkOutput("toggle_no_event", evt_count, 2);
    applyStimulus(KEY_9, 1'b1, 1'b0, 10);
    checkOutput("steady9_events", evt_count, 3);
    checkOutput("steady9_val", key_val, KEY_9);
    checkOutput("steady9_digits", digits, 16'h0059);
    applyStimulus(KEY_9, 1'b0, 1'b0, 2);
    applyStimulus(KEY_9, 1'b1, 1'b0, 1);
    applyStimulus(KEY_9, 1'b0, 1'b0, 10);
    checkOutput("bounce_no_event", evt_count, 3);

    $display("[TB] shift and saturation");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(seq_keys[i], 1'b1, 1'b0, 7);
      applyStimulus(seq_keys[i], 1'b0, 1'b0, 6);
      checkOutput("shift_digits", digits, seq_digits[i]);
      checkOutput("shift_cnt", digit_cnt, seq_cnt[i]);
      checkOutput("shift_val", key_val, seq_keys[i]);
    end
    checkOutput("shift_events", evt_count, 8);

    $display("[TB] clear coinciding with event");
    applyStimulus(KEY_7, 1'b1, 1'b0, 5);
    applyStimulus(KEY_7, 1'b1, 1'b1, 1);
    checkOutput("clrevt_pulse", key_valid, 1);
    checkOutput("clrevt_digits", digits, 16'h0007);
    checkOutput("clrevt_cnt", digit_cnt, 1);
    checkOutput("clrevt_val", key_val, KEY_7);
    applyStimulus(KEY_7, 1'b1, 1'b0, 4);
    applyStimulus(KEY_7, 1'b0, 1'b0, 8);
    checkOutput("clrevt_events", evt_count, 9);

    $display("[TB] long hold of 3");
    base = ev_cyc.size();
    applyStimulus(KEY_3, 1'b1, 1'b0, 60);
    applyStimulus(KEY_3, 1'b0, 1'b0, 10);
    checkOutput("hold_val", key_val, KEY_3);
`ifdef KEYPAD_REPEAT_EN
    checkOutput("repeat_events", evt_count, 15);
    if (ev_cyc.size() >= base + 6) begin
      checkOutput("repeat_gap1", ev_cyc[base+1] - ev_cyc[base], 20);
      for (int i = 2; i < 6; i++)
        checkOutput("repeat_gapn", ev_cyc[base+i] - ev_cyc[base+i-1], 8);
    end
    checkOutput("repeat_digits", digits, 16'h3333);
    checkOutput("repeat_cnt", digit_cnt, 4);
`else
    checkOutput("norepeat_events", evt_count, 10);
    checkOutput("norepeat_digits", digits, 16'h0073);
    checkOutput("norepeat_cnt", digit_cnt, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry_buf.md
Name: keypad_entry_buf

Overview:
- Downstream consumer of the 4x4 keypad scanner.
- Takes the scanner's raw 4-bit key code and press flag, debounces them, and converts each physical keystroke into exactly one single-cycle key event.
- Shifts each accepted hex digit into an NDIGITS-wide digit register that feeds the seven-segment display driver.
- Tolerates the scanner's column-walk glitches on code/press by requiring stable input for a programmable number of cycles.

Parameters:
- DEB_CYC, 20000: number of consecutive stable samples required to accept a press or a release; must be >= 2.
- NDIGITS, 4: number of hex digits held in the digit register.
- REP_DLY, 25000000: cycles in HELD before the first auto-repeat; used only with KEYPAD_REPEAT_EN.
- REP_PER, 5000000: cycles between subsequent auto-repeats; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock; same clock as the scanner.
- rst  in  1  synchronous reset, active-high.
- key_code  in  4  hex code from the scanner.
- key_press  in  1  press flag from the scanner; 1 = some key down.
- clr  in  1  synchronous clear of the digit register and count.
- key_valid  out  1  one-cycle pulse per accepted key event.
- key_val  out  4  code of the last accepted event; held between events.
- digits  out  4*NDIGITS  entered digits; newest digit in [3:0].
- digit_cnt  out  clog2(NDIGITS+1)  number of digits entered; saturates at NDIGITS.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - key_valid=0, key_val=0, digits=0, digit_cnt=0.
  - Internal counters and candidate code cleared.
  - Reset mid-debounce or mid-hold abandons the keystroke; no event is emitted.
- All outputs are registered. key_valid goes high the cycle after the accepting transition.
- FSM states: IDLE, ARM, HELD, REL.
  - IDLE: if key_press=1, latch cand=key_code, cnt=0, go to ARM.
  - ARM:
    - key_press=0: go to IDLE with no event.
    - key_code != cand: reload cand=key_code, cnt=0, stay in ARM.
    - Otherwise cnt++.
    - When cnt==DEB_CYC-1 with the input still matching: go to HELD and emit an event with cand.
  - HELD:
    - key_press=0: go to REL, cnt=0.
    - A code change while pressed is ignored; there is no rollover and no second event.
  - REL:
    - key_press=1: return to HELD; this is a bounce, and no new event is emitted.
    - Otherwise cnt++. At cnt==DEB_CYC-1, go to IDLE.
- Latency: a steady press first sampled at edge 0 gives key_valid=1 during cycle DEB_CYC+1, i.e. after DEB_CYC+1 consecutive matching samples.
- Event actions, all in one edge:
  - key_val <= cand.
  - digits <= {digits[4*NDIGITS-5:0], cand}; the oldest digit is discarded.
  - digit_cnt <= min(digit_cnt+1, NDIGITS).
- clr:
  - Sets digits=0 and digit_cnt=0. Does not affect the FSM, key_val or key_valid.
  - clr and an event in the same cycle: clear first, then shift, so digits={0…,cand} and digit_cnt=1.
- Counter width is clog2(max(DEB_CYC, REP_DLY, REP_PER)). Counters never wrap; they reset on every state change.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - While in HELD, a repeat counter runs.
  - After REP_DLY cycles in HELD, emit an event with cand, then one event every REP_PER cycles while held.
  - Leaving HELD (to REL) resets the repeat counter. A bounce back from REL to HELD restarts REP_DLY.
- Undefined: no repeat logic is synthesized, HELD emits no events, and REP_DLY/REP_PER are unused.

Decomposition:
- Package keypad_pkg contains:
  - The 2-bit state encoding: IDLE=0, ARM=1, HELD=2, REL=3.
  - Constants KEY_0 through KEY_F for the 16 codes.
  - A function clog2.
- Sub-module keypad_debounce:
  - Contains the FSM, the counters and the optional repeat logic.
  - Outputs an event strobe plus cand.
- The top level keeps the digit shift register, digit_cnt, key_val and key_valid.

Test Plan (DEB_CYC=4, NDIGITS=4, REP_DLY=20, REP_PER=8):
- Reset: rst=1 for 2 cycles with key_press=1 -> key_valid never pulses and digits=0x0000. After release of rst with press still held steady, exactly one event occurs.
- Clean press: key_code=5, key_press=1 held for 10 cycles, then released for 10 cycles -> key_valid=1 for one cycle, 5 cycles after the first press sample; key_val=5; digits=0x0005; digit_cnt=1.
- Glitch rejection:
  - Press with the code toggling 5/9 every 2 cycles -> no event.
  - Then the code held at 9 -> one event with key_val=9.
  - Release bouncing (press low 2 cycles, high 1 cycle, low 6 cycles) -> no second event.
- Shift and saturation: keys 1,2,3,4,A entered -> digits=0x234A and digit_cnt=4 after the fifth key.
- clr: clr=1 in the same cycle as an event for key 7 -> digits=0x0007, digit_cnt=1.
- Repeat, with KEYPAD_REPEAT_EN defined: hold key 3 for 60 cycles -> events at acceptance, then after +20, +28, +36, … cycles.
- Repeat, without the macro: the same stimulus gives exactly one event.
